// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg: refresh sequencer state encoding and DDR3 {ras,cas,we} command encodings
package ddr_cmd_pkg;
  typedef enum logic [2:0] {IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC} ref_state_t;
  typedef logic [2:0] ddr_cmd_t;
  localparam ddr_cmd_t CMD_NOP     = 3'b000;
  localparam ddr_cmd_t CMD_PRE_ALL = 3'b101;
  localparam ddr_cmd_t CMD_REF     = 3'b110;
endpackage

// File: rtl/ddr_refresh_sequencer_if.sv
// ddr_refresh_sequencer_if: refresh request, arbiter handshake and command-bus signals
// master: the refresh sequencer; slave: request counter, arbiter and PHY command mux
interface ddr_refresh_sequencer_if;
  logic en, want, need, banks_open, bus_grant;
  logic grant, bus_rq, bus_urgent, bus_own;
  logic cmd_en, cmd_ras, cmd_cas, cmd_we, cmd_a10;
  modport master (
    input  en, want, need, banks_open, bus_grant,
    output grant, bus_rq, bus_urgent, bus_own, cmd_en, cmd_ras, cmd_cas, cmd_we, cmd_a10
  );
  modport slave (
    output en, want, need, banks_open, bus_grant,
    input  grant, bus_rq, bus_urgent, bus_own, cmd_en, cmd_ras, cmd_cas, cmd_we, cmd_a10
  );
endinterface

// File: rtl/ddr_cmd_timer.sv
// ddr_cmd_timer: loadable down-counter that stops at zero and flags it
// ports: clk, rst (async), i_load/i_val load, o_zero while count is 0
module ddr_cmd_timer #(
  parameter int CNTR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [CNTR_W-1:0] i_val,
  output logic              o_zero
);
  logic [CNTR_W-1:0] r_cnt;
  assign o_zero = r_cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (!o_zero) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/ddr_refresh_sequencer.sv
// ddr_refresh_sequencer: arbitrates for the command bus, closes banks, issues REFRESH and holds tRFC
// ports: clk, rst (async, active-high), rif (master modport: request pair, arbiter handshake, command outputs)
module ddr_refresh_sequencer
  import ddr_cmd_pkg::*;
#(
  parameter int T_RP   = 6,
  parameter int T_RFC  = 88,
  parameter int CNTR_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  ddr_refresh_sequencer_if.master  rif
);
  ref_state_t        r_state, w_next;
  logic              w_zero, w_load;
  logic [CNTR_W-1:0] w_load_val;
  ddr_cmd_t          w_cmd;
  logic              r_grant, r_bus_rq, r_bus_urgent, r_bus_own, r_cmd_en, r_a10;
  ddr_cmd_t          r_cmd;
  // timer is loaded on entry to PRE/REF and counts through that cycle too,
  // so the following wait state exits exactly T_RP/T_RFC cycles after the command
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = rif.en && rif.want ? REQ : IDLE;
      REQ:      w_next = rif.bus_grant ? (rif.banks_open ? PRE : REF) : (rif.en ? REQ : IDLE);
      PRE:      w_next = WAIT_RP;
      WAIT_RP:  w_next = w_zero ? REF : WAIT_RP;
      REF:      w_next = WAIT_RFC;
      WAIT_RFC: w_next = !w_zero ? WAIT_RFC : (rif.en && rif.want && rif.need ? REF : IDLE);
      default:  w_next = IDLE;
    endcase
  end
  assign w_load     = w_next == PRE || w_next == REF;
  assign w_load_val = w_next == PRE ? CNTR_W'(T_RP - 1) : CNTR_W'(T_RFC - 1);
  assign w_cmd      = w_next == PRE ? CMD_PRE_ALL : w_next == REF ? CMD_REF : CMD_NOP;
  ddr_cmd_timer #(.CNTR_W(CNTR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_zero (w_zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_bus_rq     <= 1'b0;
      r_bus_urgent <= 1'b0;
      r_bus_own    <= 1'b0;
      r_cmd_en     <= 1'b0;
      r_a10        <= 1'b0;
      r_cmd        <= CMD_NOP;
    end else begin
      r_state      <= w_next;
      r_grant      <= w_next == REF;
      r_bus_rq     <= w_next == REQ;
      r_bus_urgent <= w_next == REQ && rif.need;
      r_bus_own    <= w_next inside {PRE, WAIT_RP, REF, WAIT_RFC};
      r_cmd_en     <= w_load;
      r_a10        <= w_next == PRE;
      r_cmd        <= w_cmd;
    end
  assign rif.grant      = r_grant;
  assign rif.bus_rq     = r_bus_rq;
  assign rif.bus_urgent = r_bus_urgent;
  assign rif.bus_own    = r_bus_own;
  assign rif.cmd_en     = r_cmd_en;
  assign {rif.cmd_ras, rif.cmd_cas, rif.cmd_we} = r_cmd;
  assign rif.cmd_a10    = r_a10;
endmodule

// File: tb/tb_ddr_refresh_sequencer.sv
// tb_ddr_refresh_sequencer: random upstream backlog, arbiter and reset stimulus against an event-scheduling model
module tb_ddr_refresh_sequencer;
  localparam int T_RP  = 4;
  localparam int T_RFC = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ddr_refresh_sequencer_if rif ();
  ddr_refresh_sequencer #(.T_RP(T_RP), .T_RFC(T_RFC), .CNTR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .rif (rif)
  );
  int n_chk = 0, n_fail = 0;
  int cyc = 0, t_ref, t_pre, cnt = 0, inc_div;
  int dut_grants = 0, exp_grants = 0;
  bit m_rq, m_own, m_urg;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask
  function automatic logic [7:0] obs_out();
    return {rif.grant, rif.bus_rq, rif.bus_own, rif.cmd_en, rif.cmd_ras, rif.cmd_cas, rif.cmd_we, rif.cmd_a10};
  endfunction
  function automatic logic [7:0] exp_out();
    bit pre, rf;
    pre = m_own && cyc == t_pre;
    rf  = m_own && cyc == t_ref;
    return {rf, m_rq, m_own, pre | rf, pre | rf, rf, pre, pre};
  endfunction
  task automatic model_reset();
    m_rq = 0; m_own = 0; m_urg = 0;
    t_ref = -1000; t_pre = -1000;
  endtask
  task automatic model_step();
    if (m_rq) begin
      if (rif.bus_grant) begin
        m_rq = 0; m_own = 1;
        if (rif.banks_open) begin
          t_pre = cyc + 1;
          t_ref = cyc + 1 + T_RP;
        end else t_ref = cyc + 1;
      end else if (!rif.en) m_rq = 0;
    end else if (m_own) begin
      if (cyc + 1 == t_ref + T_RFC) begin
        if (rif.en && rif.want && rif.need) t_ref = cyc + 1;
        else m_own = 0;
      end
    end else if (rif.en && rif.want) m_rq = 1;
    m_urg = m_rq && rif.need;
    cyc++;
  endtask
  task automatic drive_and_step();
    if (m_own && cyc == t_ref && cnt > 0) cnt--;
    if ($urandom_range(0, inc_div) == 0 && cnt < 15) cnt++;
    rif.en         = $urandom_range(0, 15) != 0;
    rif.want       = cnt != 0;
    rif.need       = cnt >= 8;
    rif.banks_open = $urandom_range(0, 1) == 1;
    rif.bus_grant  = m_rq ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) == 0;
    model_step();
  endtask
  initial begin
    rif.en = 0; rif.want = 0; rif.need = 0; rif.banks_open = 0; rif.bus_grant = 0;
    inc_div = 3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {24'd0, obs_out()}, 32'd0);
    check("reset_urgent", {31'd0, rif.bus_urgent}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_and_step();
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      check("outputs", {24'd0, obs_out()}, {24'd0, exp_out()});
      check("bus_urgent", {31'd0, rif.bus_urgent}, {31'd0, m_urg});
      dut_grants += int'(rif.grant);
      exp_grants += int'(exp_out() >> 7);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        check("async_reset", {23'd0, rif.bus_urgent, obs_out()}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      inc_div = i < 2000 ? 3 : i < 4000 ? 60 : 10;
      drive_and_step();
    end
    check("grant_total", dut_grants, exp_grants);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
